// File: rtl/sa_autosa_shift_sat_pipe.sv
// Two-stage multi-lane signed-amount shifter with round-half-up, signed/unsigned saturation,
// valid/ready flow control and a sticky saturation event counter.
module sa_autosa_shift_sat_pipe #(
  parameter int LANES       = 4,
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         autosa_core_clk,
  input  logic                         autosa_core_rstn,
  input  logic                         in_pvld,
  output logic                         in_prdy,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0]       in_shift,
  input  logic                         in_round,
  input  logic                         in_signed,
  output logic                         out_pvld,
  input  logic                         out_prdy,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]             out_sat,
  output logic [CNT_WIDTH-1:0]         sat_cnt,
  input  logic                         sat_cnt_clr
);

  localparam int SHIFT_MAX = 1 << (SHIFT_WIDTH - 1);
  // One spare bit above the widest left shift keeps every result representable as signed.
  localparam int EW        = IN_WIDTH + SHIFT_MAX + 1;

  localparam logic signed [EW-1:0] ONE_W = EW'(1);
  localparam logic signed [EW-1:0] SMAX  = (ONE_W <<< (OUT_WIDTH - 1)) - ONE_W;
  localparam logic signed [EW-1:0] SMIN  = -(ONE_W <<< (OUT_WIDTH - 1));
  localparam logic signed [EW-1:0] UMAX  = (ONE_W <<< OUT_WIDTH) - ONE_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                    r_s1_vld;
  logic signed [EW-1:0]    r_s1_val [LANES];
  logic [LANES-1:0]        r_s1_guard;
  logic                    r_s1_rnd;
  logic                    r_s1_sgn;

  logic                    r_s2_vld;
  logic [LANES*OUT_WIDTH-1:0] r_out_data;
  logic [LANES-1:0]        r_out_sat;
  logic [CNT_WIDTH-1:0]    r_sat_cnt;

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    w_neg;
  logic [SHIFT_WIDTH-1:0]  w_mag;
  logic [SHIFT_WIDTH-1:0]  w_gidx;
  logic [IN_WIDTH-1:0]     w_gmask;
  logic [IN_WIDTH-1:0]     w_lane  [LANES];
  logic signed [EW-1:0]    w_ext   [LANES];
  logic signed [EW-1:0]    w_shf   [LANES];
  logic [LANES-1:0]        w_guard;
  logic signed [EW-1:0]    w_sum   [LANES];
  logic [OUT_WIDTH-1:0]    w_res   [LANES];
  logic [LANES-1:0]        w_sat;
  logic                    w_cnt_inc;

  assign w_s2_adv = !r_s2_vld || out_prdy;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign in_prdy  = w_s1_adv;

  assign w_neg   = in_shift[SHIFT_WIDTH-1];
  assign w_mag   = w_neg ? (~in_shift + SHIFT_WIDTH'(1)) : in_shift;
  assign w_gidx  = in_shift - SHIFT_WIDTH'(1);
  assign w_gmask = {{(IN_WIDTH-1){1'b0}}, 1'b1} << w_gidx;

  // Stage 1: extend, shift, and capture the guard bit just below the kept LSB.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane[i]  = in_data[i*IN_WIDTH +: IN_WIDTH];
      w_ext[i]   = in_signed ? {{(EW-IN_WIDTH){w_lane[i][IN_WIDTH-1]}}, w_lane[i]}
                             : {{(EW-IN_WIDTH){1'b0}}, w_lane[i]};
      w_shf[i]   = w_neg ? (w_ext[i] <<< w_mag) : (w_ext[i] >>> w_mag);
      w_guard[i] = |(w_lane[i] & w_gmask);
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_s1_vld   <= 1'b0;
      r_s1_guard <= '0;
      r_s1_rnd   <= 1'b0;
      r_s1_sgn   <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s1_val[i] <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_pvld;
      if (in_pvld) begin
        r_s1_guard <= w_guard;
        r_s1_rnd   <= in_round && !w_neg && (in_shift != '0);
        r_s1_sgn   <= in_signed;
        for (int i = 0; i < LANES; i++) r_s1_val[i] <= w_shf[i];
      end
    end
  end

  // Stage 2: round then clamp to the output range of the beat's mode.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_sum[i] = r_s1_val[i] + EW'(r_s1_rnd & r_s1_guard[i]);
      w_res[i] = w_sum[i][OUT_WIDTH-1:0];
      w_sat[i] = 1'b0;
      if (r_s1_sgn) begin
        if (w_sum[i] > SMAX) begin
          w_res[i] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
          w_sat[i] = 1'b1;
        end else if (w_sum[i] < SMIN) begin
          w_res[i] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
          w_sat[i] = 1'b1;
        end
      end else if (w_sum[i] > UMAX) begin
        w_res[i] = {OUT_WIDTH{1'b1}};
        w_sat[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_s2_vld   <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_sat <= w_sat;
        for (int i = 0; i < LANES; i++) r_out_data[i*OUT_WIDTH +: OUT_WIDTH] <= w_res[i];
      end
    end
  end

  assign w_cnt_inc = r_s2_vld && out_prdy && (|r_out_sat);

  // Clear wins, but an event in the same cycle is still counted.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= w_cnt_inc ? CNT_WIDTH'(1) : '0;
    end else if (w_cnt_inc && (r_sat_cnt != CNT_MAX)) begin
      r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign out_pvld = r_s2_vld;
  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;
  assign sat_cnt  = r_sat_cnt;

endmodule

// File: tb/tb_sa_autosa_shift_sat_pipe.sv
// Directed bench for sa_autosa_shift_sat_pipe; narrow counter so the sticky ceiling is reachable.
module tb_sa_autosa_shift_sat_pipe;

  localparam int LANES = 4;
  localparam int IW    = 49;
  localparam int OW    = 32;
  localparam int SW    = 6;
  localparam int CW    = 3;

  logic               clk;
  logic               rstn;
  logic               in_pvld;
  logic               in_prdy;
  logic [LANES*IW-1:0] in_data;
  logic [SW-1:0]      in_shift;
  logic               in_round;
  logic               in_signed;
  logic               out_pvld;
  logic               out_prdy;
  logic [LANES*OW-1:0] out_data;
  logic [LANES-1:0]   out_sat;
  logic [CW-1:0]      sat_cnt;
  logic               sat_cnt_clr;

  int n_chk = 0;
  int n_err = 0;

  sa_autosa_shift_sat_pipe #(
    .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_data         (in_data),
    .in_shift        (in_shift),
    .in_round        (in_round),
    .in_signed       (in_signed),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_sat         (out_sat),
    .sat_cnt         (sat_cnt),
    .sat_cnt_clr     (sat_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [IW-1:0] l0, l1, l2, l3,
                        input logic [SW-1:0] sh, input logic rnd, sgn);
    in_data   = {l3, l2, l1, l0};
    in_shift  = sh;
    in_round  = rnd;
    in_signed = sgn;
  endtask

  // One beat through an empty pipeline; outputs sampled one cycle after acceptance.
  task automatic beat(input string tag, input logic [IW-1:0] l0, l1, l2, l3,
                      input logic [SW-1:0] sh, input logic rnd, sgn,
                      input logic [127:0] exp_d, input logic [3:0] exp_s);
    @(negedge clk);
    set_in(l0, l1, l2, l3, sh, rnd, sgn);
    in_pvld = 1'b1;
    @(posedge clk); #1;
    in_pvld = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_vld"}, 128'(out_pvld), 128'(1));
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_sat"}, 128'(out_sat), 128'(exp_s));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; in_pvld = 1'b0; out_prdy = 1'b1; sat_cnt_clr = 1'b0;
    set_in('0, '0, '0, '0, '0, 1'b0, 1'b0);
    #23;
    chk("rst_pvld", 128'(out_pvld), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_sat", 128'(out_sat), 128'(0));
    chk("rst_cnt", 128'(sat_cnt), 128'(0));
    @(negedge clk); rstn = 1'b1;
    #1 chk("rst_prdy", 128'(in_prdy), 128'(1));

    // unsigned right shift by 4, truncate then round
    beat("u_s4_trunc", 49'h1F8, 49'h1F8, 49'h18, 49'hF, 6'd4, 1'b0, 1'b0,
         {32'h0, 32'h1, 32'h1F, 32'h1F}, 4'b0000);
    beat("u_s4_round", 49'h1F8, 49'h1F8, 49'h18, 49'hF, 6'd4, 1'b1, 1'b0,
         {32'h1, 32'h2, 32'h20, 32'h20}, 4'b0000);
    // unsigned left shift by 8
    beat("u_sm8", 49'h00FFFFFF, 49'h01000000, 49'h1, 49'h0, 6'h38, 1'b1, 1'b0,
         {32'h0, 32'h100, 32'hFFFFFFFF, 32'hFFFFFF00}, 4'b0010);
    tick();
    chk("cnt_1", 128'(sat_cnt), 128'(1));
    // signed right shift by 1 with rounding
    beat("s_s1_round", 49'h1_FFFF_FFFF_FFFB, 49'h5, 49'h1_FFFF_FFFF_FFFA, 49'h2, 6'd1, 1'b1, 1'b1,
         {32'h1, 32'hFFFFFFFD, 32'h3, 32'hFFFFFFFE}, 4'b0000);
    // signed pass-through; rounding ignored at s=0
    beat("s_s0_clamp", 49'h100_0000_0000, 49'h1_FF00_0000_0000, 49'h1_FFFF_FFFF_FFFF, 49'h7FFFFFFF,
         6'd0, 1'b1, 1'b1, {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF}, 4'b0011);
    // max right shift with round
    beat("u_s31_round", 49'h1_0000_4000_0000, 49'h0, 49'h0, 49'h0, 6'd31, 1'b1, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'h00020001}, 4'b0000);
    // rounding carry past 2^32 must saturate rather than wrap
    beat("u_s17_carry", 49'h1_FFFF_FFFF_FFFF, 49'h0, 49'h0, 49'h0, 6'd17, 1'b1, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    beat("u_s17_trunc", 49'h1_FFFF_FFFF_FFFF, 49'h0, 49'h0, 49'h0, 6'd17, 1'b0, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0000);
    // max left shift
    beat("u_sm32", 49'h1, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    beat("s_sm32", 49'h1_FFFF_FFFF_FFFF, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b1,
         {32'h0, 32'h0, 32'h0, 32'h80000000}, 4'b0001);
    tick();
    chk("cnt_5", 128'(sat_cnt), 128'(5));

    // clear coinciding with a saturating handshake
    beat("clr_beat", 49'h1, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_inc", 128'(sat_cnt), 128'(1));

    for (int k = 0; k < 6; k++)
      beat("fill", 49'h1, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b0,
           {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    tick();
    chk("cnt_max", 128'(sat_cnt), 128'(7));
    beat("stick", 49'h1, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    tick();
    chk("cnt_stick", 128'(sat_cnt), 128'(7));

    @(negedge clk); sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_clr", 128'(sat_cnt), 128'(0));

    // backpressure: two beats fill the pipe, the third waits
    out_prdy = 1'b0;
    @(negedge clk); set_in(49'hA1, '0, '0, '0, 6'd0, 1'b0, 1'b0); in_pvld = 1'b1;
    tick();
    chk("bp_prdy_a", 128'(in_prdy), 128'(1));
    @(negedge clk); set_in(49'hB2, '0, '0, '0, 6'd0, 1'b0, 1'b0);
    tick();
    chk("bp_full", 128'(in_prdy), 128'(0));
    chk("bp_a", out_data, 128'h0A1);
    @(negedge clk); set_in(49'hC3, '0, '0, '0, 6'd0, 1'b0, 1'b0);
    tick();
    chk("bp_hold", out_data, 128'h0A1);
    chk("bp_hold_vld", 128'(out_pvld), 128'(1));
    chk("bp_stall", 128'(in_prdy), 128'(0));
    @(negedge clk); out_prdy = 1'b1;
    tick();
    chk("bp_b", out_data, 128'h0B2);
    @(negedge clk); in_pvld = 1'b0;
    tick();
    chk("bp_c", out_data, 128'h0C3);
    chk("bp_c_vld", 128'(out_pvld), 128'(1));
    tick();
    chk("bp_empty", 128'(out_pvld), 128'(0));

    // async reset with a held saturating beat plus one in flight
    out_prdy = 1'b0;
    beat("pre_rst", 49'h1, 49'h0, 49'h0, 49'h0, 6'h20, 1'b0, 1'b0,
         {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001);
    @(negedge clk); set_in(49'h77, '0, '0, '0, 6'd0, 1'b0, 1'b0); in_pvld = 1'b1;
    tick();
    in_pvld = 1'b0;
    out_prdy = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("arst_pvld", 128'(out_pvld), 128'(0));
    chk("arst_sat", 128'(out_sat), 128'(0));
    chk("arst_data", out_data, 128'(0));
    chk("arst_cnt", 128'(sat_cnt), 128'(0));
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_vld", 128'(out_pvld), 128'(0));
    end
    chk("post_rst_prdy", 128'(in_prdy), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
